// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, instruction fields,
// ALU operation codes, datapath select values and the bundled control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_R     = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_REGIMM = 6'b000001,
                         OP_J     = 6'b000010, OP_JAL    = 6'b000011,
                         OP_BEQ   = 6'b000100, OP_BNE    = 6'b000101,
                         OP_BLEZ  = 6'b000110, OP_BGTZ   = 6'b000111,
                         OP_ADDI  = 6'b001000, OP_SLTI   = 6'b001010,
                         OP_ANDI  = 6'b001100, OP_ORI    = 6'b001101,
                         OP_XORI  = 6'b001110,
                         OP_LB    = 6'b100000, OP_LH     = 6'b100001,
                         OP_LW    = 6'b100011, OP_SB     = 6'b101000,
                         OP_SH    = 6'b101001, OP_SW     = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL = 6'b000010, F_JR  = 6'b001000,
                         F_MULT = 6'b011000, F_ADD = 6'b100000, F_SUB = 6'b100010,
                         F_AND  = 6'b100100, F_OR  = 6'b100101, F_XOR = 6'b100110,
                         F_NOR  = 6'b100111, F_SLT = 6'b101010;

  localparam logic [4:0] RT_BLTZ = 5'b00000, RT_BGEZ = 5'b00001;

  localparam logic [3:0] ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_MULT = 4'b0010,
                         ALU_BGTZ = 4'b0011, ALU_BGEZ = 4'b0100, ALU_BNE  = 4'b0101,
                         ALU_BLEZ = 4'b0110, ALU_BLTZ = 4'b0111, ALU_AND  = 4'b1000,
                         ALU_OR   = 4'b1001, ALU_NOR  = 4'b1010, ALU_XOR  = 4'b1011,
                         ALU_SLL  = 4'b1100, ALU_SRL  = 4'b1101, ALU_SLT  = 4'b1110;

  localparam logic [1:0] SZ_IDLE = 2'b00, SZ_BYTE = 2'b01, SZ_HALF = 2'b10, SZ_WORD = 2'b11;
  localparam logic [1:0] SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_BR = 2'b11;
  localparam logic [1:0] RDST_RT = 2'b00, RDST_RD = 2'b01, RDST_RA = 2'b10;
  localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
  localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10, PCS_REGA = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic [1:0] mem_read;
    logic [1:0] mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  function automatic logic [1:0] mem_size(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return SZ_WORD;
      OP_LH, OP_SH: return SZ_HALF;
      OP_LB, OP_SB: return SZ_BYTE;
      default:      return SZ_IDLE;
    endcase
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Instruction-to-ALU-operation map. The code is what EXEC_R/EXEC_I/BRANCH drive;
// legal is low for any opcode/funct/rt combination the controller must trap.
import mc_ctrl_pkg::*;

module mc_alu_decode (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   alu_ctrl = ALU_ADD;
          F_SUB:   alu_ctrl = ALU_SUB;
          F_MULT:  alu_ctrl = ALU_MULT;
          F_AND:   alu_ctrl = ALU_AND;
          F_OR:    alu_ctrl = ALU_OR;
          F_NOR:   alu_ctrl = ALU_NOR;
          F_XOR:   alu_ctrl = ALU_XOR;
          F_SLL:   alu_ctrl = ALU_SLL;
          F_SRL:   alu_ctrl = ALU_SRL;
          F_SLT:   alu_ctrl = ALU_SLT;
          F_JR:    alu_ctrl = ALU_ADD;
          default: legal    = 1'b0;
        endcase
      end
      OP_ADDI: alu_ctrl = ALU_ADD;
      OP_ANDI: alu_ctrl = ALU_AND;
      OP_ORI:  alu_ctrl = ALU_OR;
      OP_XORI: alu_ctrl = ALU_XOR;
      OP_SLTI: alu_ctrl = ALU_SLT;
      OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB, OP_J, OP_JAL: alu_ctrl = ALU_ADD;
      // BEQ has no dedicated code: equality is the SUB zero flag
      OP_BEQ:  alu_ctrl = ALU_SUB;
      OP_BNE:  alu_ctrl = ALU_BNE;
      OP_BGTZ: alu_ctrl = ALU_BGTZ;
      OP_BLEZ: alu_ctrl = ALU_BLEZ;
      OP_REGIMM: begin
        if (rt == RT_BLTZ)      alu_ctrl = ALU_BLTZ;
        else if (rt == RT_BGEZ) alu_ctrl = ALU_BGEZ;
        else                    legal    = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: Moore decode of the state into datapath enables and
// selects, with MemReady stalls in FETCH/MEM_RD/MEM_WR and BranchTaken gating PCWrite.
import mc_ctrl_pkg::*;

module mc_controller (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic [4:0] Rt,
  input  logic       BranchTaken,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic [1:0] MemRead,
  output logic [1:0] MemWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t     state, nxt;
  ctrl_t      c;
  logic [3:0] dec_alu;
  logic       dec_legal;

  mc_alu_decode u_dec (
    .opcode   (Opcode),
    .funct    (Funct),
    .rt       (Rt),
    .alu_ctrl (dec_alu),
    .legal    (dec_legal)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_FETCH;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    c   = '0;
    case (state)
      S_FETCH: begin
        c.mem_read  = SZ_WORD;
        c.alu_src_b = SRCB_FOUR;
        if (MemReady) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          nxt        = S_DECODE;
        end
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_BR;
        if (!dec_legal) nxt = S_TRAP;
        else begin
          case (Opcode)
            OP_RTYPE: nxt = (Funct == F_JR) ? S_JR : S_EXEC_R;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: nxt = S_EXEC_I;
            OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB:   nxt = S_MEM_ADDR;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: nxt = S_BRANCH;
            OP_J, OP_JAL: nxt = S_JUMP;
            default:      nxt = S_TRAP;
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = (state == S_EXEC_R) ? SRCB_REG : SRCB_IMM;
        c.alu_ctrl  = dec_alu;
        nxt         = (state == S_EXEC_R) ? S_WB_R : S_WB_I;
      end
      S_WB_R: begin
        c.reg_write = 1'b1;
        c.reg_dst   = RDST_RD;
        nxt         = S_FETCH;
      end
      S_WB_I: begin
        c.reg_write = 1'b1;
        nxt         = S_FETCH;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        nxt         = is_load(Opcode) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        c.iord     = 1'b1;
        c.mem_read = mem_size(Opcode);
        if (MemReady) nxt = S_WB_MEM;
      end
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_MDR;
        nxt          = S_FETCH;
      end
      S_MEM_WR: begin
        c.iord      = 1'b1;
        c.mem_write = mem_size(Opcode);
        if (MemReady) nxt = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_ctrl  = dec_alu;
        c.pc_source = PCS_ALUOUT;
        c.pc_write  = BranchTaken;
        nxt         = S_FETCH;
      end
      S_JUMP: begin
        c.pc_source = PCS_JUMP;
        c.pc_write  = 1'b1;
        // PC already holds PC+4 here, which is the JAL link value
        if (Opcode == OP_JAL) begin
          c.reg_write  = 1'b1;
          c.reg_dst    = RDST_RA;
          c.mem_to_reg = M2R_PC;
        end
        nxt = S_FETCH;
      end
      S_JR: begin
        c.pc_source = PCS_REGA;
        c.pc_write  = 1'b1;
        nxt         = S_FETCH;
      end
      S_TRAP: begin
        c.illegal = 1'b1;
        nxt       = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
    if (Reset) begin
      c.pc_write  = 1'b0;
      c.ir_write  = 1'b0;
      c.reg_write = 1'b0;
      c.mem_read  = SZ_IDLE;
      c.mem_write = SZ_IDLE;
      c.illegal   = 1'b0;
    end
  end

  assign PCWrite    = c.pc_write;
  assign IRWrite    = c.ir_write;
  assign IorD       = c.iord;
  assign MemRead    = c.mem_read;
  assign MemWrite   = c.mem_write;
  assign RegWrite   = c.reg_write;
  assign RegDst     = c.reg_dst;
  assign MemToReg   = c.mem_to_reg;
  assign ALUSrcA    = c.alu_src_a;
  assign ALUSrcB    = c.alu_src_b;
  assign ALUControl = c.alu_ctrl;
  assign PCSource   = c.pc_source;
  assign IllegalOp  = c.illegal;
  assign State      = state;

endmodule
